adder_tree_input_collector: RTL

- Writer side of the adder-tree input interface: gathers a serial stream of F_NBITS-bit field words into a parallel ngates-entry v_parts array.
- Presents the array as a held, stable frame to a downstream adder tree, then clears it for the next frame once the consumer acknowledges.
- Sits between per-gate serial producers and the combinational reduction tree.

---
 rtl/adder_tree_input_collector.sv | 63 ++++++
 1 files changed

// File: rtl/adder_tree_input_collector.sv
// adder_tree_input_collector: packs a serial word stream into a held v_parts frame for an adder tree.
// Define COLLECTOR_RUNSUM_EN to add a runsum output that tracks the frame sum.
`ifndef F_NBITS
`define F_NBITS 61
`endif
module adder_tree_input_collector #(
   parameter int ngates = 8,
   localparam int cbits = $clog2(ngates + 1)
) (
   input  logic                             clk,
   input  logic                             rstb,
   input  logic [`F_NBITS-1:0]              in_data,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [ngates-1:0][`F_NBITS-1:0]  v_parts,
   output logic                             parts_valid,
   input  logic                             parts_ack,
   output logic [cbits-1:0]                 count
`ifdef COLLECTOR_RUNSUM_EN
   ,
   output logic [`F_NBITS-1:0]              runsum
`endif
);
   typedef enum logic {FILL, HOLD} state_t;
   state_t state, state_nx;
   logic accept, done, clear;
   assign in_ready = (state == FILL) && rstb;
   assign accept = in_valid && in_ready;
   assign done = accept && (in_last || count == cbits'(ngates - 1));
   assign clear = (state == HOLD) && parts_ack;
   always_comb begin
      state_nx = state;
      if (done) state_nx = HOLD;
      else if (clear) state_nx = FILL;
   end
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state <= FILL;
         v_parts <= '0;
         count <= '0;
         parts_valid <= 1'b0;
      end else begin
         state <= state_nx;
         parts_valid <= (state_nx == HOLD);
         if (accept) begin
            for (int i = 0; i < ngates; i++)
               if (count == cbits'(i)) v_parts[i] <= in_data;
            count <= count + 1'b1;
         end else if (clear) begin
            v_parts <= '0;
            count <= '0;
         end
      end
   end
`ifdef COLLECTOR_RUNSUM_EN
   // Truncating add, matching the downstream tree's modulo arithmetic.
   always_ff @(posedge clk) begin
      if (!rstb || clear) runsum <= '0;
      else if (accept) runsum <= runsum + in_data;
   end
`endif
endmodule
